// File: rtl/btn_pkg.sv
// Shared types and constants for the button event generator: channel state,
// per-channel event bundle, default timing and board button indices.
package btn_pkg;

  typedef enum logic [1:0] {
    DISARMED = 2'd0,
    IDLE     = 2'd1,
    PRESSED  = 2'd2,
    HELD     = 2'd3
  } btn_state_t;

  typedef struct packed {
    logic press;
    logic rel;
    logic lng;
    logic rpt;
  } btn_evt_t;

  localparam int HOLD_CYCLES_DEF   = 50000000;
  localparam int REPEAT_CYCLES_DEF = 10000000;

  localparam int BTN_C = 0;
  localparam int BTN_U = 1;
  localparam int BTN_D = 2;
  localparam int BTN_L = 3;
  localparam int BTN_R = 4;

  // Counter must hold terminal values of both the hold and the repeat phase.
  function automatic int cnt_width(int hold, int rep);
    int m;
    m = (hold > rep) ? hold : rep;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/btn_event_channel.sv
// One button channel: DISARMED/IDLE/PRESSED/HELD FSM, hold/repeat counter and
// registered event pulses. Repeat generation is present only with BTN_REPEAT_EN.
module btn_event_channel
  import btn_pkg::*;
#(
  parameter int HOLD_CYCLES   = HOLD_CYCLES_DEF,
  parameter int REPEAT_CYCLES = REPEAT_CYCLES_DEF
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     btn_db,
  output btn_evt_t evt,
  output logic     held,
  output logic     press_nxt
);

  localparam int CW = cnt_width(HOLD_CYCLES, REPEAT_CYCLES);

  btn_state_t      state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  btn_evt_t        evt_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= DISARMED;
      cnt   <= '0;
      evt   <= '0;
      held  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      evt   <= evt_n;
      held  <= (state_n == HELD);
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    evt_n   = '0;
    case (state)
      // A button held through reset must be seen released before arming.
      DISARMED: if (!btn_db) state_n = IDLE;
      IDLE: if (btn_db) begin
        state_n     = PRESSED;
        cnt_n       = '0;
        evt_n.press = 1'b1;
      end
      PRESSED: begin
        if (!btn_db) begin
          state_n   = IDLE;
          cnt_n     = '0;
          evt_n.rel = 1'b1;
        end else if (cnt == CW'(HOLD_CYCLES - 1)) begin
          state_n   = HELD;
          cnt_n     = '0;
          evt_n.lng = 1'b1;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      HELD: begin
        if (!btn_db) begin
          state_n   = IDLE;
          cnt_n     = '0;
          evt_n.rel = 1'b1;
        end
`ifdef BTN_REPEAT_EN
        else if (cnt == CW'(REPEAT_CYCLES - 1)) begin
          cnt_n     = '0;
          evt_n.rpt = 1'b1;
        end else begin
          cnt_n = cnt + CW'(1);
        end
`endif
      end
      default: state_n = DISARMED;
    endcase
  end

  // Lets the top register any_press in the same edge as press_p.
  assign press_nxt = evt_n.press;

endmodule

// File: rtl/button_event_gen.sv
// Per-button event generator: N_BTN independent channels plus registered
// any_press. Optional build macro: BTN_REPEAT_EN enables repeat_p.
module button_event_gen
  import btn_pkg::*;
#(
  parameter int N_BTN         = 5,
  parameter int HOLD_CYCLES   = HOLD_CYCLES_DEF,
  parameter int REPEAT_CYCLES = REPEAT_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_db,
  output logic [N_BTN-1:0] press_p,
  output logic [N_BTN-1:0] release_p,
  output logic [N_BTN-1:0] long_p,
  output logic [N_BTN-1:0] repeat_p,
  output logic [N_BTN-1:0] held,
  output logic             any_press
);

  btn_evt_t [N_BTN-1:0] evt;
  logic     [N_BTN-1:0] press_nxt;

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_event_channel #(
      .HOLD_CYCLES  (HOLD_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .btn_db   (btn_db[i]),
      .evt      (evt[i]),
      .held     (held[i]),
      .press_nxt(press_nxt[i])
    );
    assign press_p[i]   = evt[i].press;
    assign release_p[i] = evt[i].rel;
    assign long_p[i]    = evt[i].lng;
    assign repeat_p[i]  = evt[i].rpt;
  end

  always_ff @(posedge clk) begin
    if (rst) any_press <= 1'b0;
    else     any_press <= |press_nxt;
  end

endmodule

// File: tb/tb_button_event_gen.sv
// Directed table-driven bench for button_event_gen with HOLD=8, REPEAT=4.
module tb_button_event_gen;
  localparam int N    = 5;
  localparam int HOLD = 8;
  localparam int REP  = 4;
  localparam int NV   = 84;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] btn_db;
  logic [N-1:0] press_p, release_p, long_p, repeat_p, held;
  logic         any_press;

  always #5 clk = ~clk;

  button_event_gen #(.N_BTN(N), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP)) dut (
    .clk(clk), .rst(rst), .btn_db(btn_db),
    .press_p(press_p), .release_p(release_p), .long_p(long_p),
    .repeat_p(repeat_p), .held(held), .any_press(any_press)
  );

  // Index e: inputs sampled at edge e, expected outputs visible after edge e
  // (cycle e+1).
  typedef struct {
    logic         rst;
    logic [N-1:0] btn;
    logic [N-1:0] press, rel, lng, rpt, hld;
    logic         any;
  } vec_t;

  vec_t v[NV];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic btn_on(input int ch, input int e0, input int e1);
    for (int e = e0; e <= e1; e++) v[e].btn[ch] = 1'b1;
  endtask

  // kind: 0 press, 1 release, 2 long, 3 repeat; cyc counted as in the plan.
  task automatic pulse(input int kind, input int ch, input int cyc);
    case (kind)
      0: v[cyc-1].press[ch] = 1'b1;
      1: v[cyc-1].rel[ch]   = 1'b1;
      2: v[cyc-1].lng[ch]   = 1'b1;
      default: v[cyc-1].rpt[ch] = 1'b1;
    endcase
  endtask

  task automatic held_on(input int ch, input int c0, input int c1);
    for (int c = c0; c <= c1; c++) v[c-1].hld[ch] = 1'b1;
  endtask

  task automatic cmp(input string name, input logic [N-1:0] ep, er, el, et, eh,
                     input logic ea);
    n_vec++;
    if ({press_p, release_p, long_p, repeat_p, held, any_press} !== {ep, er, el, et, eh, ea}) begin
      n_bad++;
      $display("FAIL %s t=%0t: got press=%b rel=%b long=%b rpt=%b held=%b any=%b, want press=%b rel=%b long=%b rpt=%b held=%b any=%b",
               name, $time, press_p, release_p, long_p, repeat_p, held, any_press,
               ep, er, el, et, eh, ea);
    end
  endtask

  task automatic step(input logic r, input logic [N-1:0] b);
    @(negedge clk);
    rst    = r;
    btn_db = b;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst    = 1'b1;
    btn_db = '0;
    for (int e = 0; e < NV; e++) v[e] = '{default: '0};
    for (int e = 0; e <= 2; e++)   v[e].rst = 1'b1;
    for (int e = 40; e <= 42; e++) v[e].rst = 1'b1;

    // ch0: short press
    btn_on(0, 10, 12); pulse(0, 0, 11); pulse(1, 0, 14);
    // ch1: long hold; release coincides with repeat terminal count
    btn_on(1, 10, 29); pulse(0, 1, 11); pulse(2, 1, 19); held_on(1, 19, 30); pulse(1, 1, 31);
`ifdef BTN_REPEAT_EN
    pulse(3, 1, 23); pulse(3, 1, 27);
`endif
    // ch2: release on the edge the hold counter reaches 7
    btn_on(2, 10, 17); pulse(0, 2, 11); pulse(1, 2, 19);
    // ch3: held through reset, one-cycle drop, then a single press
    btn_on(3, 0, 14); btn_on(3, 16, 19); pulse(0, 3, 17); pulse(1, 3, 21);
    // ch4: reset mid-press, released during reset
    btn_on(4, 37, 40); pulse(0, 4, 38);
    // phase B: simultaneous press on ch0/ch4, ch0 held 30 cycles
    btn_on(0, 50, 79); btn_on(4, 50, 52);
    pulse(0, 0, 51); pulse(0, 4, 51); pulse(1, 4, 54);
    pulse(2, 0, 59); held_on(0, 59, 80); pulse(1, 0, 81);
`ifdef BTN_REPEAT_EN
    pulse(3, 0, 63); pulse(3, 0, 67); pulse(3, 0, 71); pulse(3, 0, 75); pulse(3, 0, 79);
`endif
    for (int e = 0; e < NV; e++) v[e].any = |v[e].press;

    for (int e = 0; e < NV; e++) begin
      step(v[e].rst, v[e].btn);
      cmp($sformatf("vec%0d", e), v[e].press, v[e].rel, v[e].lng, v[e].rpt, v[e].hld, v[e].any);
    end

    // All buttons held through reset: no events until each is released.
    step(1'b1, '1); cmp("rst_all_held", '0, '0, '0, '0, '0, 1'b0);
    step(1'b1, '1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, '1); cmp("disarmed_hold", '0, '0, '0, '0, '0, 1'b0);
    end
    step(1'b0, '0);      cmp("disarmed_drop", '0, '0, '0, '0, '0, 1'b0);
    step(1'b0, 5'b00100); cmp("rearm_press", 5'b00100, '0, '0, '0, '0, 1'b1);
    step(1'b0, 5'b00100); cmp("rearm_once", '0, '0, '0, '0, '0, 1'b0);
    step(1'b0, '0);      cmp("rearm_rel", '0, 5'b00100, '0, '0, '0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: run did not complete, got no summary, want summary");
    $fatal(1, "timeout");
  end

endmodule
